irq_controller: RTL and testbench

IRQ_CONTROLLER -- requirements
Module: irq_controller

---
 rtl/irq_controller_if.sv | 21 ++
 rtl/irq_controller.sv | 113 +++++++++++
 tb/tb_irq_controller.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/irq_controller_if.sv
// Register bus and core-facing interrupt signals of the interrupt controller.
// The core/bench drives through the master modport; the controller uses the slave modport.
interface irq_controller_if;
  logic        cfg_we;
  logic [2:0]  cfg_addr;
  logic [31:0] cfg_wdata;
  logic [31:0] cfg_rdata;
  logic        irq_ack;
  logic [31:0] interrupt;
  logic [4:0]  irq_id;

  modport master (
    output cfg_we, cfg_addr, cfg_wdata, irq_ack,
    input  cfg_rdata, interrupt, irq_id
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_wdata, irq_ack,
    output cfg_rdata, interrupt, irq_id
  );
endinterface

// File: rtl/irq_controller.sv
// Machine timer plus edge-triggered external interrupt controller.
// Produces mip-layout MTIP/MEIP and a lowest-index claim ID.
module irq_controller #(
  parameter int NUM_EXT = 8,
  parameter int CMP_W   = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_EXT-1:0] ext_irq_i,
  irq_controller_if.slave    bus
);
  localparam logic [2:0] ADDR_MTIME    = 3'd0;
  localparam logic [2:0] ADDR_MTIMECMP = 3'd1;
  localparam logic [2:0] ADDR_CTRL     = 3'd2;
  localparam logic [2:0] ADDR_IE       = 3'd3;
  localparam logic [2:0] ADDR_PENDING  = 3'd4;
  localparam logic [2:0] ADDR_CLAIM    = 3'd5;
  localparam logic [4:0] NO_IRQ        = 5'h1F;

  logic [CMP_W-1:0]   mtime_q, mtime_d, mtimecmp_q, mtimecmp_d;
  logic               ten_q, ten_d;
  logic [NUM_EXT-1:0] ie_q, ie_d, pending_q, pending_d;
  logic [NUM_EXT-1:0] sync1_q, sync1_d, sync2_q, sync2_d, hist_q, hist_d;
  logic [1:0]         settle_q, settle_d;
  logic               mtip_q, mtip_d, meip_q, meip_d;
  logic [4:0]         irq_id_q, irq_id_d;
  logic [NUM_EXT-1:0] edge_set, clr_mask;
  logic               wr_sel_pending;

  function automatic logic [4:0] lowest_index(input logic [NUM_EXT-1:0] v);
    lowest_index = NO_IRQ;
    for (int i = NUM_EXT - 1; i >= 0; i--) begin
      if (v[i]) lowest_index = 5'(i);
    end
  endfunction

  always_comb begin
    mtime_d    = mtime_q;
    mtimecmp_d = mtimecmp_q;
    ten_d      = ten_q;
    ie_d       = ie_q;
    if (bus.cfg_we && bus.cfg_addr == ADDR_MTIME) mtime_d = CMP_W'(bus.cfg_wdata);
    else if (ten_q)                               mtime_d = mtime_q + CMP_W'(1);
    if (bus.cfg_we && bus.cfg_addr == ADDR_MTIMECMP) mtimecmp_d = CMP_W'(bus.cfg_wdata);
    if (bus.cfg_we && bus.cfg_addr == ADDR_CTRL)     ten_d = bus.cfg_wdata[0];
    if (bus.cfg_we && bus.cfg_addr == ADDR_IE)       ie_d = bus.cfg_wdata[NUM_EXT-1:0];

    sync1_d = ext_irq_i;
    sync2_d = sync1_q;
    hist_d  = sync2_q;
    // The chain restarts from zero after reset; hold off edge detection until it
    // reflects the real line levels so a line held high across reset stays quiet.
    settle_d = (settle_q != 2'd0) ? settle_q - 2'd1 : 2'd0;
    edge_set = (settle_q == 2'd0) ? (sync2_q & ~hist_q) : '0;

    wr_sel_pending = bus.cfg_we && bus.cfg_addr == ADDR_PENDING;
    clr_mask = wr_sel_pending ? bus.cfg_wdata[NUM_EXT-1:0] : '0;
    for (int i = 0; i < NUM_EXT; i++) begin
      if (bus.irq_ack && irq_id_q == 5'(i)) clr_mask[i] = 1'b1;
    end
    pending_d = (pending_q & ~clr_mask) | edge_set;

    mtip_d   = ten_q && (mtime_q >= mtimecmp_q);
    meip_d   = |(pending_q & ie_q);
    irq_id_d = lowest_index(pending_q & ie_q);
  end

  always_comb begin
    bus.cfg_rdata = 32'h0;
    case (bus.cfg_addr)
      ADDR_MTIME:    bus.cfg_rdata = 32'(mtime_q);
      ADDR_MTIMECMP: bus.cfg_rdata = 32'(mtimecmp_q);
      ADDR_CTRL:     bus.cfg_rdata = {31'h0, ten_q};
      ADDR_IE:       bus.cfg_rdata = 32'(ie_q);
      ADDR_PENDING:  bus.cfg_rdata = 32'(pending_q);
      ADDR_CLAIM:    bus.cfg_rdata = {27'h0, irq_id_q};
      default:       bus.cfg_rdata = 32'h0;
    endcase
  end

  assign bus.interrupt = {20'h0, meip_q, 3'h0, mtip_q, 7'h0};
  assign bus.irq_id    = irq_id_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      mtime_q    <= '0;
      mtimecmp_q <= '1;
      ten_q      <= 1'b0;
      ie_q       <= '0;
      pending_q  <= '0;
      sync1_q    <= '0;
      sync2_q    <= '0;
      hist_q     <= '0;
      settle_q   <= 2'd3;
      mtip_q     <= 1'b0;
      meip_q     <= 1'b0;
      irq_id_q   <= NO_IRQ;
    end else begin
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      ten_q      <= ten_d;
      ie_q       <= ie_d;
      pending_q  <= pending_d;
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      hist_q     <= hist_d;
      settle_q   <= settle_d;
      mtip_q     <= mtip_d;
      meip_q     <= meip_d;
      irq_id_q   <= irq_id_d;
    end
  end
endmodule

// File: tb/tb_irq_controller.sv
// Self-checking bench for irq_controller: register table plus timer/external/reset sequences.
module tb_irq_controller;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] ext_irq = 8'h0;
  int         total = 0;
  int         bad = 0;

  irq_controller_if bus();

  irq_controller #(.NUM_EXT(8), .CMP_W(32)) dut (
    .clk(clk), .reset(reset), .ext_irq_i(ext_irq), .bus(bus)
  );

  always #10 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] exp;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [2:0]  waddr;
    logic [31:0] wdata;
    logic [2:0]  raddr;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[10];

  task automatic expect_val(input string n, input logic [31:0] e);
    exp_t x;
    x.name = n;
    x.exp  = e;
    sb.push_back(x);
  endtask

  task automatic observe(input logic [31:0] act);
    exp_t x;
    total++;
    if (sb.size() == 0) begin
      bad++;
      $display("FAIL scoreboard_empty: got %h with nothing expected", act);
    end else begin
      x = sb.pop_front();
      if (act !== x.exp) begin
        bad++;
        $display("FAIL %s: got %h required %h", x.name, act, x.exp);
      end
    end
  endtask

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] e);
    expect_val(n, e);
    observe(act);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    bus.cfg_we = 1'b1;
    bus.cfg_addr = a;
    bus.cfg_wdata = d;
    step();
    bus.cfg_we = 1'b0;
    bus.cfg_wdata = 32'h0;
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] d);
    bus.cfg_addr = a;
    #1;
    d = bus.cfg_rdata;
  endtask

  task automatic chk_rd(input string n, input logic [2:0] a, input logic [31:0] e);
    logic [31:0] d;
    expect_val(n, e);
    rd(a, d);
    observe(d);
  endtask

  task automatic ack_once();
    bus.irq_ack = 1'b1;
    step();
    bus.irq_ack = 1'b0;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_interrupt"}, bus.interrupt, 32'h0);
    chk({tag, "_irq_id"}, 32'(bus.irq_id), 32'h1F);
    chk_rd({tag, "_mtime"}, 3'd0, 32'h0);
    chk_rd({tag, "_mtimecmp"}, 3'd1, 32'hFFFF_FFFF);
    chk_rd({tag, "_ctrl"}, 3'd2, 32'h0);
    chk_rd({tag, "_ie"}, 3'd3, 32'h0);
    chk_rd({tag, "_pending"}, 3'd4, 32'h0);
  endtask

  initial begin
    logic [31:0] d;
    bus.cfg_we = 1'b0;
    bus.cfg_addr = 3'd0;
    bus.cfg_wdata = 32'h0;
    bus.irq_ack = 1'b0;

    vecs[0] = '{3'd1, 32'h1234_5678, 3'd1, 32'h1234_5678};
    vecs[1] = '{3'd3, 32'hFFFF_FFFF, 3'd3, 32'h0000_00FF};
    vecs[2] = '{3'd2, 32'hFFFF_FFFE, 3'd2, 32'h0};
    vecs[3] = '{3'd0, 32'hDEAD_BEEF, 3'd0, 32'hDEAD_BEEF};
    vecs[4] = '{3'd6, 32'hFFFF_FFFF, 3'd6, 32'h0};
    vecs[5] = '{3'd7, 32'hFFFF_FFFF, 3'd7, 32'h0};
    vecs[6] = '{3'd5, 32'h0, 3'd5, 32'h1F};
    vecs[7] = '{3'd4, 32'hFF, 3'd4, 32'h0};
    vecs[8] = '{3'd3, 32'h0, 3'd3, 32'h0};
    vecs[9] = '{3'd0, 32'h0, 3'd0, 32'h0};

    // Reset values are visible after the first edge with reset high.
    step();
    chk_reset_state("reset");
    chk_rd("reset_claim", 3'd5, 32'h1F);
    step();
    reset = 1'b0;

    for (int i = 0; i < 10; i++) begin
      bus.cfg_we = 1'b1;
      bus.cfg_addr = vecs[i].waddr;
      bus.cfg_wdata = vecs[i].wdata;
      expect_val($sformatf("reg_vec%0d", i), vecs[i].exp);
      step();
      bus.cfg_we = 1'b0;
      rd(vecs[i].raddr, d);
      observe(d);
    end

    // Timer compare: MTIP appears one cycle after MTIME reaches MTIMECMP.
    wr(3'd1, 32'd10);
    wr(3'd0, 32'd0);
    wr(3'd2, 32'd1);
    for (int k = 0; k < 14; k++) begin
      chk_rd($sformatf("timer_mtime_k%0d", k), 3'd0, 32'(k));
      chk($sformatf("timer_int_k%0d", k), bus.interrupt, (k >= 11) ? 32'h80 : 32'h0);
      step();
    end
    wr(3'd1, 32'hFFFF_FFFF);
    step();
    chk("timer_cmp_raised", bus.interrupt, 32'h0);
    wr(3'd2, 32'd0);

    // MTIME wrap with MTIMECMP at all-ones.
    wr(3'd0, 32'hFFFF_FFFE);
    wr(3'd2, 32'd1);
    chk_rd("wrap_m0", 3'd0, 32'hFFFF_FFFE);
    chk("wrap_i0", bus.interrupt, 32'h0);
    step();
    chk_rd("wrap_m1", 3'd0, 32'hFFFF_FFFF);
    chk("wrap_i1", bus.interrupt, 32'h0);
    step();
    chk_rd("wrap_m2", 3'd0, 32'h0);
    chk("wrap_i2", bus.interrupt, 32'h80);
    step();
    chk_rd("wrap_m3", 3'd0, 32'h1);
    chk("wrap_i3", bus.interrupt, 32'h0);

    // MTIME write coincident with an increment.
    wr(3'd0, 32'h100);
    chk_rd("mtime_write_wins", 3'd0, 32'h100);
    step();
    chk_rd("mtime_after_write", 3'd0, 32'h101);
    wr(3'd2, 32'd0);

    // External edge latency and claim/ack ordering.
    wr(3'd3, 32'h0C);
    ext_irq[3] = 1'b1;
    step();
    ext_irq[3] = 1'b0;
    chk_rd("lat_pend_k0", 3'd4, 32'h0);
    step();
    chk_rd("lat_pend_k1", 3'd4, 32'h0);
    step();
    chk_rd("lat_pend_k2", 3'd4, 32'h08);
    chk("lat_int_k2", bus.interrupt, 32'h0);
    step();
    chk("lat_int_k3", bus.interrupt, 32'h800);
    chk("lat_id_k3", 32'(bus.irq_id), 32'd3);
    ext_irq[2] = 1'b1;
    step();
    ext_irq[2] = 1'b0;
    steps(4);
    chk_rd("ext_pending", 3'd4, 32'h0C);
    chk("ext_id2", 32'(bus.irq_id), 32'd2);
    chk("ext_int", bus.interrupt, 32'h800);
    ack_once();
    step();
    chk("ack1_id3", 32'(bus.irq_id), 32'd3);
    chk_rd("ack1_pending", 3'd4, 32'h08);
    ack_once();
    step();
    chk("ack2_id", 32'(bus.irq_id), 32'h1F);
    chk("ack2_int", bus.interrupt, 32'h0);
    chk_rd("ack2_pending", 3'd4, 32'h0);

    // Masked line still pends; ack with no claim does nothing.
    wr(3'd3, 32'h0);
    ext_irq[5] = 1'b1;
    step();
    ext_irq[5] = 1'b0;
    steps(4);
    chk_rd("mask_pending", 3'd4, 32'h20);
    chk("mask_int", bus.interrupt, 32'h0);
    chk("mask_id", 32'(bus.irq_id), 32'h1F);
    ack_once();
    step();
    chk_rd("ack_noclaim_pending", 3'd4, 32'h20);
    wr(3'd3, 32'h20);
    step();
    chk("unmask_int", bus.interrupt, 32'h800);
    chk("unmask_id", 32'(bus.irq_id), 32'd5);
    wr(3'd4, 32'h20);
    chk_rd("w1c_clear", 3'd4, 32'h0);

    // W1C lands in the same cycle the edge sets the bit: set wins.
    wr(3'd3, 32'h07);
    ext_irq[1] = 1'b1;
    step();
    step();
    wr(3'd4, 32'h02);
    chk_rd("collide_set_wins", 3'd4, 32'h02);

    // Ack and W1C on different bits in one cycle.
    ext_irq = 8'h05;
    step();
    ext_irq = 8'h00;
    steps(4);
    chk_rd("ackw1c_pre", 3'd4, 32'h07);
    chk("ackw1c_id0", 32'(bus.irq_id), 32'd0);
    bus.irq_ack = 1'b1;
    wr(3'd4, 32'h04);
    bus.irq_ack = 1'b0;
    chk_rd("ackw1c_post", 3'd4, 32'h02);
    wr(3'd4, 32'hFF);
    wr(3'd3, 32'h0);

    // Reset mid-operation with line 0 held high throughout.
    wr(3'd2, 32'd1);
    ext_irq = 8'hFF;
    steps(4);
    ext_irq = 8'h01;
    step();
    chk_rd("pre_reset_pending", 3'd4, 32'hFF);
    reset = 1'b1;
    steps(2);
    chk_reset_state("midreset");
    reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      step();
      chk_rd($sformatf("held_line_quiet_k%0d", k), 3'd4, 32'h0);
    end
    ext_irq = 8'h00;
    steps(4);
    ext_irq = 8'h01;
    steps(3);
    chk_rd("retoggle_pending", 3'd4, 32'h01);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
